uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed byte on the rising edge of the receiver's done level and stores it in a circular FIFO. Bytes are presented to the host/bus logic through a first-word-fall-through valid/ready interface. It also reports occupancy and a sticky overflow flag.

Parameters:
DATA_WIDTH, 8, width of a received byte and of each FIFO entry.
DEPTH, 16, number of FIFO entries; must be a power of 2 and at least 2. Pointer width is the derived local value $clog2(DEPTH).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
rx_byte  input  DATA_WIDTH  byte from the UART receiver; stable while rx_done is high.
rx_done  input  1  receiver done level; high for one or more clk cycles per byte.
rd_data  output  DATA_WIDTH  head-of-FIFO byte; valid only when rd_valid=1.
rd_valid  output  1  FIFO non-empty.
rd_ready  input  1  consumer accepts rd_data this cycle.
count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
full  output  1  count==DEPTH.
empty  output  1  count==0.
overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at a clk edge), all take effect that edge:
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0, rx_done_d=0.
  - Outputs become rd_valid=0, empty=1, full=0.
  - Storage array is not reset.
  - Reset mid-operation discards all stored bytes.
  - If rx_done is high during reset, rx_done_d=0 still applies, so a level still high after reset is treated as a new edge and is written.
- Capture strobe:
  - push = rx_done & ~rx_done_d, evaluated combinationally each cycle.
  - rx_done_d <= rx_done every cycle.
  - Exactly one push per rx_done high period, regardless of its length. Back-to-back high levels with no low cycle produce one push.
- Write: on push with a free slot (or simultaneous pop, see below):
  - mem[wr_ptr] <= rx_byte.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
- Read (first-word fall-through):
  - rd_valid = ~empty; rd_data = mem[rd_ptr] combinationally.
  - pop = rd_valid & rd_ready.
  - On pop: rd_ptr <= rd_ptr+1, wrapping DEPTH-1 -> 0.
  - rd_data is don't-care when empty.
  - rd_ready while empty has no effect.
- Latency: push accepted at edge N -> rd_valid=1 and rd_data=byte after edge N (a write to an empty FIFO is visible the next cycle). No same-cycle bypass from rx_byte to rd_data.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full boundary:
  - push while full and pop in the same cycle: push is accepted, count stays DEPTH.
  - push while full and no pop: byte dropped, pointers and count unchanged, overflow <= 1.
- Empty boundary: pop impossible; push while empty gives count=1.
- overflow:
  - Set on a dropped push.
  - Cleared by overflow_clr=1 at a clk edge.
  - If a drop and overflow_clr occur in the same cycle, set wins and overflow stays 1.
  - overflow does not block further writes once space exists.
- full and empty are decoded from count. count and the pointers use a wrap-safe encoding so full and empty are unambiguous at DEPTH entries.
- No state machine beyond the edge detector, pointers and flags. All outputs except rd_data are registered or decoded from registers.

Test Plan:
1. Single byte: after reset, rx_byte=0xA5, rx_done high for 40 cycles, rd_ready=0 -> exactly one entry; count=1, rd_valid=1, rd_data=0xA5 from the cycle after the push edge; asserting rd_ready one cycle -> count=0, rd_valid=0.
2. Ordering and wrap: push 0x00..0x17 (24 bytes), each followed by rd_ready pulses so occupancy stays ≤4 -> bytes read out in order 0x00..0x17 across pointer wrap; overflow=0 throughout.
3. Full/overflow: with rd_ready=0, push 0x10..0x20 (17 bytes) into DEPTH=16 -> full=1, count=16, overflow=1, 0x20 dropped; draining gives 0x10..0x1F then empty=1.
4. Simultaneous push+pop at full: FIFO full, rd_ready=1 in the same cycle as a push of 0x55 -> count stays 16, overflow unchanged, 0x55 read last after draining.
5. overflow_clr: overflow=1, assert overflow_clr -> overflow=0 next cycle; repeat with a dropped push in the same cycle -> overflow stays 1.
6. Reset mid-operation: count=5, assert rst for one cycle -> count=0, empty=1, rd_valid=0, overflow=0; subsequent push of 0x3C is read back as the first byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: edge-captures each completed byte
// into a circular FIFO and presents it through a first-word-fall-through valid/ready port.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    rx_byte,
   input  logic                     rx_done,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             overflow_q, overflow_d;
   logic             rx_done_q;

   logic push, pop, wr_en, drop;

   // Count carries one extra bit so DEPTH entries is distinct from zero entries.
   assign full     = (count_q == CNT_MAX);
   assign empty    = (count_q == '0);
   assign rd_valid = ~empty;
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

   assign push  = rx_done & ~rx_done_q;
   assign pop   = rd_valid & rd_ready;
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow_d = 1'b1;
      else if (overflow_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rx_done_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rx_done_q  <= rx_done;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_ptr_q] <= rx_byte;
   end

endmodule
